pc_sequencer: RTL and testbench



---
 rtl/pc_sequencer_pkg.sv | 19 +
 rtl/pc_sequencer_ret_stack.sv | 65 ++++++
 rtl/pc_sequencer.sv | 121 ++++++++++++
 tb/tb_pc_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch-side PC sequencer and the control-unit decode.
// Optional feature macro used by this slice: PC_STALL_EN (adds a stall input).
package pc_sequencer_pkg;

  // Default instruction-address width.
  localparam int PC_W_DEF = 10;

  // PC value loaded on reset.
  localparam logic [PC_W_DEF-1:0] RESET_PC = {PC_W_DEF{1'b0}};

  // Next-PC source select shared with the uc-side decode.
  typedef enum logic [1:0] {
    SEL_INC  = 2'd0,
    SEL_JMP  = 2'd1,
    SEL_CALL = 2'd2,
    SEL_RET  = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO: DEPTH x PC_W registers, write pointer equals depth.
// Push writes entry[depth], pop reads entry[depth-1]; push and pop are never
// requested together by the sequencer.
module ret_stack #(
  parameter int PC_W  = 10,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [PC_W-1:0]            push_data_i,
  output logic [PC_W-1:0]            top_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     depth_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;

  logic [PC_W-1:0] mem_q [DEPTH];
  logic [DW-1:0]   depth_q;
  logic [DW-1:0]   depth_d;
  logic [AW-1:0]   wr_idx_s;
  logic [AW-1:0]   top_idx_s;
  logic [DW-1:0]   top_full_s;

  assign full_o     = (depth_q == DW'(DEPTH));
  assign empty_o    = (depth_q == DW'(0));
  assign wr_idx_s   = depth_q[AW-1:0];
  assign top_full_s = depth_q - DW'(1);
  assign top_idx_s  = top_full_s[AW-1:0];
  assign top_o      = mem_q[top_idx_s];
  assign depth_o    = depth_q;

  // Depth counter next state: grow on accepted push, shrink on accepted pop.
  always_comb begin
    depth_d = depth_q;
    if (push_i && !full_o) begin
      depth_d = depth_q + DW'(1);
    end else if (pop_i && !empty_o) begin
      depth_d = depth_q - DW'(1);
    end else begin
      depth_d = depth_q;
    end
  end

  // Depth counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      depth_q <= DW'(0);
    end else begin
      depth_q <= depth_d;
    end
  end

  // Entry storage; contents are don't-care after reset so no reset is applied.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) begin
      mem_q[wr_idx_s] <= push_data_i;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage with a hardware return-address stack.
// Define PC_STALL_EN to add a `stall` input that freezes PC, stack and flags.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
`ifdef PC_STALL_EN
  input  logic                   stall,
`endif
  input  logic                   s_inc,
  input  logic [PC_W-1:0]        jump_addr,
  input  logic                   call,
  input  logic                   ret,
  output logic [PC_W-1:0]        pc,
  output logic [$clog2(DEPTH):0] depth,
  output logic                   ovf,
  output logic                   unf
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic            ovf_q;
  logic            ovf_d;
  logic            unf_q;
  logic            unf_d;
  logic [PC_W-1:0] pc_inc_s;
  logic [PC_W-1:0] stk_top_s;
  logic            stk_full_s;
  logic            stk_empty_s;
  logic            push_s;
  logic            pop_s;
  logic            stall_s;
  pc_sel_e         sel_s;

`ifdef PC_STALL_EN
  assign stall_s = stall;
`else
  assign stall_s = 1'b0;
`endif

  // Increment wraps modulo 2^PC_W naturally through truncation.
  assign pc_inc_s = pc_q + PC_W'(1);

  ret_stack #(
    .PC_W  (PC_W),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push_s),
    .pop_i       (pop_s),
    .push_data_i (pc_inc_s),
    .top_o       (stk_top_s),
    .full_o      (stk_full_s),
    .empty_o     (stk_empty_s),
    .depth_o     (depth)
  );

  // Decode priority ret > call > jump > increment, then select the next PC.
  always_comb begin
    sel_s  = SEL_INC;
    push_s = 1'b0;
    pop_s  = 1'b0;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    pc_d   = pc_q;
    if (stall_s) begin
      pc_d = pc_q;
    end else begin
      if (ret) begin
        if (!stk_empty_s) begin
          sel_s = SEL_RET;
          pop_s = 1'b1;
        end else begin
          sel_s = SEL_INC;
          unf_d = 1'b1;
        end
      end else if (call) begin
        sel_s = SEL_CALL;
        if (!stk_full_s) begin
          push_s = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end else if (!s_inc) begin
        sel_s = SEL_JMP;
      end else begin
        sel_s = SEL_INC;
      end
      case (sel_s)
        SEL_INC:  pc_d = pc_inc_s;
        SEL_JMP:  pc_d = jump_addr;
        SEL_CALL: pc_d = jump_addr;
        SEL_RET:  pc_d = stk_top_s;
        default:  pc_d = pc_inc_s;
      endcase
    end
  end

  // PC and sticky flag registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_PC[PC_W-1:0];
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign pc  = pc_q;
  assign ovf = ovf_q;
  assign unf = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed plan plus randomized traffic
// against a queue-based reference model. Honours PC_STALL_EN when defined.
module tb_pc_sequencer;

  localparam int PC_W  = 10;
  localparam int DEPTH = 4;
  localparam int PC_MOD = 1 << PC_W;

  logic            clk;
  logic            reset;
  logic            stall;
  logic            s_inc;
  logic [PC_W-1:0] jump_addr;
  logic            call;
  logic            ret;
  logic [PC_W-1:0] pc;
  logic [2:0]      depth;
  logic            ovf;
  logic            unf;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference model state
  int m_pc = 0;
  int m_stk[$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  pc_sequencer #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef PC_STALL_EN
    .stall     (stall),
`endif
    .s_inc     (s_inc),
    .jump_addr (jump_addr),
    .call      (call),
    .ret       (ret),
    .pc        (pc),
    .depth     (depth),
    .ovf       (ovf),
    .unf       (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs and advance the model by the architectural rules.
  task automatic cyc(input bit r, input bit si, input int ja, input bit c,
                     input bit rt, input bit st);
    reset     = r;
    s_inc     = si;
    jump_addr = PC_W'(ja);
    call      = c;
    ret       = rt;
    stall     = st;
    @(posedge clk);
    if (r) begin
      m_pc = 0;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
`ifdef PC_STALL_EN
    end else if (st) begin
      m_pc = m_pc;
`endif
    end else if (rt) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else begin
        m_unf = 1'b1;
        m_pc  = (m_pc + 1) % PC_MOD;
      end
    end else if (c) begin
      if (m_stk.size() < DEPTH) m_stk.push_back((m_pc + 1) % PC_MOD);
      else m_ovf = 1'b1;
      m_pc = ja % PC_MOD;
    end else if (!si) begin
      m_pc = ja % PC_MOD;
    end else begin
      m_pc = (m_pc + 1) % PC_MOD;
    end
    #1;
  endtask

  task automatic inc(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Compare process: every settled cycle the outputs must match the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("pc",    int'(pc),    m_pc);
      check("depth", int'(depth), m_stk.size());
      check("ovf",   int'(ovf),   int'(m_ovf));
      check("unf",   int'(unf),   int'(m_unf));
    end
  end

  // Directed plan followed by randomized traffic.
  initial begin
    int r_ja;
    bit r_rst, r_si, r_c, r_rt, r_st;
    cyc(1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    check("reset_pc", int'(pc), 0);
    check("reset_depth", int'(depth), 0);

    // Sequential fetch
    inc(5);
    check("inc5_pc", int'(pc), 5);

    // Wrap at top of address space, then plain jump
    cyc(1'b0, 1'b0, 1020, 1'b0, 1'b0, 1'b0);
    inc(3);
    check("pc_max", int'(pc), 1023);
    inc(1);
    check("pc_wrap", int'(pc), 0);
    cyc(1'b0, 1'b0, 'h155, 1'b0, 1'b0, 1'b0);
    check("jump_pc", int'(pc), 'h155);

    // Single call / return
    cyc(1'b0, 1'b0, 'h010, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 'h100, 1'b1, 1'b0, 1'b0);
    check("call_pc", int'(pc), 'h100);
    check("call_depth", int'(depth), 1);
    cyc(1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0);
    check("ret_pc", int'(pc), 'h011);
    check("ret_depth", int'(depth), 0);

    // Nesting beyond capacity, full unwind, then one extra return
    cyc(1'b0, 1'b0, 'h020, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) cyc(1'b0, 1'b0, 'h40 * i, 1'b1, 1'b0, 1'b0);
    check("nest_depth", int'(depth), 4);
    check("nest_ovf", int'(ovf), 1);
    check("nest_pc", int'(pc), 'h140);
    cyc(1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0);
    check("pop1", int'(pc), 'h0C1);
    cyc(1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0);
    check("pop2", int'(pc), 'h081);
    cyc(1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0);
    check("pop3", int'(pc), 'h041);
    cyc(1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0);
    check("pop4", int'(pc), 'h021);
    check("pop4_unf", int'(unf), 0);
    cyc(1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0);
    check("under_pc", int'(pc), 'h022);
    check("under_unf", int'(unf), 1);

    // call and ret together: return wins
    cyc(1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 'h050, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 'h060, 1'b1, 1'b0, 1'b0);
    check("two_depth", int'(depth), 2);
    cyc(1'b0, 1'b0, 'h300, 1'b1, 1'b1, 1'b0);
    check("both_pc", int'(pc), 'h051);
    check("both_depth", int'(depth), 1);
    check("both_ovf", int'(ovf), 0);

    // Reset during a call with depth 3
    cyc(1'b0, 1'b1, 'h070, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 'h080, 1'b1, 1'b0, 1'b0);
    check("three_depth", int'(depth), 3);
    cyc(1'b1, 1'b1, 'h090, 1'b1, 1'b0, 1'b0);
    check("rst_call_pc", int'(pc), 0);
    check("rst_call_depth", int'(depth), 0);
    check("rst_call_ovf", int'(ovf), 0);

`ifdef PC_STALL_EN
    inc(4);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 'h3FF, 1'b1, 1'b0, 1'b1);
    check("stall_pc", int'(pc), 4);
    check("stall_depth", int'(depth), 0);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(0, 99) == 0);
      r_c   = ($urandom_range(0, 5) == 0);
      r_rt  = ($urandom_range(0, 5) == 0);
      r_si  = ($urandom_range(0, 3) != 0);
      r_ja  = int'($urandom_range(0, PC_MOD - 1));
`ifdef PC_STALL_EN
      r_st  = ($urandom_range(0, 7) == 0);
`else
      r_st  = 1'b0;
`endif
      cyc(r_rst, r_si, r_ja, r_c, r_rt, r_st);
    end

    chk_en = 1'b0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
